// File: rtl/afpm_byte_sequencer.sv
// +--------------------------------------------------------------------------+
// | afpm_byte_sequencer                                                      |
// | Byte-serial operand assembly, core start/done handshake with timeout,    |
// | and byte-serial result return for the logarithmic FP16 multiplier.       |
// | Optional feature macro: AFPM_SEQ_ZERO_SHORTCUT_EN                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module afpm_byte_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter logic [15:0] NAN_CODE    = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  a_byte,
    input  logic [7:0]  b_byte,
    input  logic        byte_valid,
    output logic [15:0] core_a,
    output logic [15:0] core_b,
    output logic        core_start,
    input  logic        core_done,
    input  logic [15:0] core_result,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    output logic        out_last,
    output logic        busy,
    output logic        err_overrun,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_SEND_LO = 3'd4,
        S_SEND_HI = 3'd5
    } state_t;

    localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [15:0] core_a_q, core_a_d;
    logic [15:0] core_b_q, core_b_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        core_start_q, core_start_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        busy_q, busy_d;
    logic        err_overrun_q, err_overrun_d;
    logic        err_timeout_q, err_timeout_d;

    always_comb begin
        state_d       = state_q;
        core_a_d      = core_a_q;
        core_b_d      = core_b_q;
        result_d      = result_q;
        cnt_d         = cnt_q;
        core_start_d  = core_start_q;
        out_byte_d    = out_byte_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        busy_d        = busy_q;
        err_overrun_d = err_overrun_q;
        err_timeout_d = err_timeout_q;

        if (ena) begin
            core_start_d = 1'b0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (byte_valid) begin
                        core_a_d[7:0] = a_byte;
                        core_b_d[7:0] = b_byte;
                        state_d       = S_LOAD_HI;
                    end
                end
                S_LOAD_HI: begin
                    if (byte_valid) begin
                        core_a_d[15:8] = a_byte;
                        core_b_d[15:8] = b_byte;
                        state_d        = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
`ifdef AFPM_SEQ_ZERO_SHORTCUT_EN
                    if ((core_a_q[14:0] == 15'd0) || (core_b_q[14:0] == 15'd0)) begin
                        result_d = {core_a_q[15] ^ core_b_q[15], 15'd0};
                        state_d  = S_SEND_LO;
                    end
`endif
                end
                S_WAIT: begin
                    cnt_d = cnt_q + 8'd1;
                    // A done landing on the final counted cycle still wins.
                    if (core_done) begin
                        result_d = core_result;
                        state_d  = S_SEND_LO;
                    end else if (cnt_d == c_timeout) begin
                        result_d      = NAN_CODE;
                        err_timeout_d = 1'b1;
                        state_d       = S_SEND_LO;
                    end
                end
                S_SEND_LO: begin
                    out_byte_d  = result_q[7:0];
                    out_valid_d = 1'b1;
                    state_d     = S_SEND_HI;
                end
                S_SEND_HI: begin
                    out_byte_d  = result_q[15:8];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            if (byte_valid && (state_q inside {S_ISSUE, S_WAIT, S_SEND_LO, S_SEND_HI}))
                err_overrun_d = 1'b1;

            // Start is registered from the next state so it is visible the cycle ISSUE is entered.
            core_start_d = (state_d == S_ISSUE);
`ifdef AFPM_SEQ_ZERO_SHORTCUT_EN
            if ((core_a_d[14:0] == 15'd0) || (core_b_d[14:0] == 15'd0))
                core_start_d = 1'b0;
`endif
            busy_d = !((state_d == S_IDLE) || (state_d == S_LOAD_HI));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            core_a_q      <= '0;
            core_b_q      <= '0;
            result_q      <= '0;
            cnt_q         <= '0;
            core_start_q  <= 1'b0;
            out_byte_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_a_q      <= core_a_d;
            core_b_q      <= core_b_d;
            result_q      <= result_d;
            cnt_q         <= cnt_d;
            core_start_q  <= core_start_d;
            out_byte_q    <= out_byte_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign core_a      = core_a_q;
    assign core_b      = core_b_q;
    assign core_start  = core_start_q;
    assign out_byte    = out_byte_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_afpm_byte_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_afpm_byte_sequencer                                                   |
// | Directed scoreboard bench for afpm_byte_sequencer with a simple core.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_afpm_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic        byte_valid;
    logic [15:0] core_a;
    logic [15:0] core_b;
    logic        core_start;
    logic        core_done;
    logic [15:0] core_result;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        err_overrun;
    logic        err_timeout;

    afpm_byte_sequencer #(
        .TIMEOUT_CYC (16),
        .NAN_CODE    (16'h7E00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .a_byte      (a_byte),
        .b_byte      (b_byte),
        .byte_valid  (byte_valid),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .busy        (busy),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks    = 0;
    int          errors    = 0;
    int          start_cnt = 0;
    int          starts0;
    int          core_k    = 0;
    logic [15:0] core_val  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_result(input logic [15:0] r);
        exp_q.push_back('{b: r[7:0],  last: 1'b0});
        exp_q.push_back('{b: r[15:8], last: 1'b1});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
        byte_valid = 1'b1;
        a_byte     = a;
        b_byte     = b;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy || out_valid || (exp_q.size() != 0)) begin
            if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s timeout actual=busy_or_pending required=idle", name);
                break;
            end
            step();
            n++;
        end
    endtask

    // Core model: answers core_k cycles after the start pulse (0 = never).
    initial begin
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (ena && core_start && (core_k != 0)) begin
                int          kk;
                logic [15:0] rv;
                kk = core_k;
                rv = core_val;
                repeat (kk) @(posedge clk);
                #1;
                core_done   = 1'b1;
                core_result = rv;
                @(posedge clk);
                #1;
                core_done = 1'b0;
            end
        end
    end

    // Monitor: each presented beat is consumed on an enabled edge.
    always @(negedge clk) begin
        if (rst_n && ena) begin
            if (core_start) start_cnt++;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat_unexpected actual=%h/%b required=none", out_byte, out_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ((out_byte !== mon_e.b) || (out_last !== mon_e.last)) begin
                        errors++;
                        $display("FAIL out_beat actual=%h/%b required=%h/%b",
                                 out_byte, out_last, mon_e.b, mon_e.last);
                    end
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        a_byte     = '0;
        b_byte     = '0;
        byte_valid = 1'b0;
        repeat (3) step();

        chk("rst_core_a", {16'd0, core_a}, 32'd0);
        chk("rst_core_b", {16'd0, core_b}, 32'd0);
        chk("rst_ctrl", {out_byte, core_start, out_valid, out_last, busy, err_overrun, err_timeout}, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic product with latency check (edge 0 = high beat).
        core_k = 3; core_val = 16'h4C3A;
        push_result(16'h4C3A);
        starts0 = start_cnt;
        send_beat(8'hB9, 8'h7B);
        send_beat(8'h48, 8'h3F);
        chk("basic_core_a", {16'd0, core_a}, 32'h48B9);
        chk("basic_core_b", {16'd0, core_b}, 32'h3F7B);
        chk("basic_start_edge0", {31'd0, core_start}, 32'd1);
        repeat (4) step();
        chk("basic_no_out_edge4", {31'd0, out_valid}, 32'd0);
        step();
        chk("basic_lo_edge5", {23'd0, out_valid, out_byte}, 32'h13A);
        wait_idle("basic", 20);
        chk("basic_single_start", start_cnt - starts0, 32'd1);
        chk("basic_busy", {31'd0, busy}, 32'd0);

        // Gap between beats.
        push_result(16'h4C3A);
        send_beat(8'hB9, 8'h7B);
        repeat (5) step();
        chk("gap_hold_not_busy", {30'd0, busy, core_start}, 32'd0);
        send_beat(8'h48, 8'h3F);
        chk("gap_core_a", {16'd0, core_a}, 32'h48B9);
        wait_idle("gap", 20);
        chk("gap_no_err", {30'd0, err_overrun, err_timeout}, 32'd0);

        // Done on the last allowed WAIT cycle wins over the timeout.
        core_k = 16; core_val = 16'h1234;
        push_result(16'h1234);
        send_beat(8'h00, 8'h00);
        send_beat(8'h3C, 8'h3C);
        wait_idle("done16", 40);
        chk("done16_no_timeout", {31'd0, err_timeout}, 32'd0);

        // Core never answers.
        core_k = 0;
        push_result(16'h7E00);
        send_beat(8'h11, 8'h22);
        send_beat(8'h33, 8'h44);
        repeat (17) step();
        chk("timeout_flag_edge17", {30'd0, err_timeout, out_valid}, 32'h2);
        step();
        chk("timeout_lo_edge18", {23'd0, out_valid, out_byte}, 32'h100);
        wait_idle("timeout", 20);

        // Overrun during WAIT.
        core_k = 6; core_val = 16'hABCD;
        push_result(16'hABCD);
        send_beat(8'h01, 8'h02);
        send_beat(8'h03, 8'h04);
        step();
        send_beat(8'hFF, 8'hFF);
        chk("ovr_flag", {31'd0, err_overrun}, 32'd1);
        chk("ovr_operands", {core_a, core_b}, 32'h0301_0402);
        wait_idle("overrun", 20);
        core_k = 2; core_val = 16'h1357;
        push_result(16'h1357);
        starts0 = start_cnt;
        send_beat(8'h10, 8'h20);
        send_beat(8'h30, 8'h40);
        chk("ovr_next_operands", {core_a, core_b}, 32'h3010_4020);
        wait_idle("overrun_next", 20);
        chk("ovr_next_start", start_cnt - starts0, 32'd1);

        // ena low while the low result byte is presented.
        core_k = 3; core_val = 16'h4C3A;
        push_result(16'h4C3A);
        send_beat(8'hB9, 8'h7B);
        send_beat(8'h48, 8'h3F);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ena_freeze", {22'd0, out_valid, out_last, out_byte}, 32'h23A);
        end
        ena = 1'b1;
        wait_idle("ena", 20);

        // Async reset during WAIT; the late done must be ignored.
        core_k = 5; core_val = 16'hFFFF;
        send_beat(8'h55, 8'h66);
        send_beat(8'h77, 8'h11);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_wait_ops", {core_a, core_b}, 32'd0);
        chk("rst_wait_ctrl", {out_byte, core_start, out_valid, out_last, busy, err_overrun, err_timeout}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("rst_late_done", {29'd0, busy, out_valid, err_timeout}, 32'd0);

        // Zero operand.
        core_k = 2; core_val = 16'h8000;
        push_result(16'h8000);
        starts0 = start_cnt;
        send_beat(8'h00, 8'h00);
        send_beat(8'h80, 8'h3C);
        wait_idle("zero", 20);
`ifdef AFPM_SEQ_ZERO_SHORTCUT_EN
        chk("zero_no_start", start_cnt - starts0, 32'd0);
`else
        chk("zero_start", start_cnt - starts0, 32'd1);
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/afpm_byte_sequencer.md
Name: afpm_byte_sequencer

Overview:
- Sequencer between the 8-bit Tiny Tapeout pins and the 16-bit logarithmic approximate FP16 multiplier core.
- Assembles operands A and B from two byte-serial beats, low byte first. Issues one start pulse to the core and waits for done, with a timeout.
- Returns the 16-bit product as two output beats, low byte first.
- Sits inside tt_um_logarithmic_afpm, between ui_in/uio_in/uo_out and the multiplier datapath.

Parameters:
- TIMEOUT_CYC, 16: max cycles spent in WAIT before the core is abandoned (range 2..255).
- NAN_CODE, 16'h7E00: FP16 value returned on timeout.

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low freezes the FSM and all registers
- a_byte  in  8  operand A byte (ui_in)
- b_byte  in  8  operand B byte (uio_in)
- byte_valid  in  1  a_byte/b_byte valid this cycle
- core_a  out  16  operand A to core; held stable ISSUE..WAIT
- core_b  out  16  operand B to core; held stable ISSUE..WAIT
- core_start  out  1  one-cycle start pulse
- core_done  in  1  core result valid (single-cycle pulse)
- core_result  in  16  core product, sampled when core_done=1
- out_byte  out  8  result byte (uo_out)
- out_valid  out  1  out_byte valid
- out_last  out  1  high on the second (high) result byte
- busy  out  1  FSM not in IDLE or LOAD_HI
- err_overrun  out  1  sticky: byte_valid arrived while not accepting
- err_timeout  out  1  sticky: core did not answer within TIMEOUT_CYC

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - core_a, core_b, out_byte = 0.
  - core_start, out_valid, out_last, busy, err_overrun, err_timeout = 0.
  - Takes effect mid-operation too. A core_done pending at reset is ignored.
- All outputs are registered. With ena=0, nothing changes; inputs are ignored, including byte_valid and core_done.
- FSM states: IDLE, LOAD_HI, ISSUE, WAIT, SEND_LO, SEND_HI.
- IDLE: on byte_valid, core_a[7:0]<=a_byte and core_b[7:0]<=b_byte; go to LOAD_HI.
- LOAD_HI:
  - On byte_valid, load core_a[15:8] and core_b[15:8]; go to ISSUE.
  - Without byte_valid, stay. There is no inter-beat timeout.
- ISSUE: core_start=1 for exactly this one cycle; wait counter cleared; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On core_done: capture core_result; go to SEND_LO. core_done wins if it arrives in the same cycle the counter reaches TIMEOUT_CYC.
  - When the counter reaches TIMEOUT_CYC without done: captured result=NAN_CODE, err_timeout<=1, go to SEND_LO.
  - core_done outside WAIT is ignored.
- SEND_LO: out_byte=result[7:0], out_valid=1, out_last=0; go to SEND_HI.
- SEND_HI: out_byte=result[15:8], out_valid=1, out_last=1; go to IDLE.
  - A byte_valid in this cycle is an overrun. It is not captured; the new low beat is accepted from the following IDLE cycle.
- Overrun: byte_valid while in ISSUE, WAIT, SEND_LO or SEND_HI sets err_overrun and is dropped. Only reset clears it.
- out_byte holds its last value when out_valid=0.
- Latency, counting the edge that samples the high beat as edge 0 and a core answering k cycles after start:
  - core_start is high after edge 0.
  - The low result byte is valid after edge k+2.
  - The high result byte is valid after edge k+3.

Optional Feature:
- Macro: AFPM_SEQ_ZERO_SHORTCUT_EN.
- Defined:
  - In ISSUE, if core_a[14:0]==0 or core_b[14:0]==0, core_start is not asserted.
  - Result becomes {core_a[15]^core_b[15], 15'b0} and the FSM goes straight to SEND_LO.
  - Result bytes appear one cycle after ISSUE.
- Not defined: zero operands are always sent to the core like any other value.

Test Plan:
- Basic product:
  - Stimulus: beats (B9,7B) then (48,3F); core model asserts done 3 cycles after start with 0x4C3A.
  - Required: core_a=0x48B9, core_b=0x3F7B; single core_start; out_byte=3A (out_last=0), then 4C (out_last=1); busy returns to 0.
- Gap between beats: 5 idle cycles between the low and high beats.
  - Required: state holds LOAD_HI; result is the same as the basic-product case; no errors.
- Timeout, with TIMEOUT_CYC=16:
  - Core never answers: result bytes 00, 7E; err_timeout=1.
  - Done arrives on cycle 16: core result is used and err_timeout=0.
- Overrun: byte_valid during WAIT.
  - Required: err_overrun=1; operands unchanged; the next transaction after SEND_HI completes normally.
- Reset and ena:
  - rst_n pulsed low during WAIT: all outputs return to 0 immediately; a later core_done is ignored.
  - ena=0 for 4 cycles during SEND_LO: out_byte stays 3A; sequence resumes when ena returns.
- Zero shortcut (macro defined): A=0x8000, B=0x3C00.
  - Required: no core_start; bytes 00, 80.
  - Macro undefined: core_start is issued.
